i2c_reg_decode: RTL and testbench

I2C_REG_DECODE -- requirements
Module: i2c_reg_decode

---
 rtl/i2c_reg_decode.sv | 130 +++++++++++++
 tb/tb_i2c_reg_decode.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_decode.sv
// I2C slave register-access decoder: pointer byte selects port/offset, following bytes
// write or read the selected port. Optional stuck-bus timeout via macro I2C_DEC_TIMEOUT_EN.
module i2c_reg_decode #(
  parameter logic [15:0] PORT_MASK   = 16'hFFFF,
  parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
  input  logic        SYSCLK,
  input  logic        RESET_N,
  input  logic        START_DET,
  input  logic        STOP_DET,
  input  logic        ADDR_VLD,
  input  logic        ADDR_RW,
  input  logic        RX_VLD,
  input  logic [7:0]  RX_DATA,
  input  logic        TX_REQ,
  input  logic [7:0]  RD_DATA,
  output logic [7:0]  TX_DATA,
  output logic        TX_VLD,
  output logic [15:0] PORT_CS_ALL,
  output logic [15:0] OFFSET_SEL,
  output logic        RD_WR,
  output logic [7:0]  DIN
);

  typedef enum logic [2:0] {IDLE, WAIT_ADDR, WAIT_PTR, WRITE, READ, FETCH} state_t;

  state_t      state, state_nxt;
  logic [7:0]  ptr;
  logic        wr_pend;
  logic        fetch_late;
  logic        timeout;
  logic        port_ok;
  logic [15:0] port_hot;
  logic        rd_start;
  logic        fetch_done;

`ifdef I2C_DEC_TIMEOUT_EN
  logic [15:0] to_cnt;
  logic        any_pulse;

  assign any_pulse = START_DET | STOP_DET | ADDR_VLD | RX_VLD | TX_REQ;
  assign timeout   = (state != IDLE) && !any_pulse && (to_cnt == TIMEOUT_CYC - 16'd1);

  always_ff @(posedge SYSCLK) begin
    if (!RESET_N) begin
      to_cnt <= '0;
    end else if (any_pulse || state == IDLE || timeout) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 16'd1;
    end
  end
`else
  logic timeout_cyc_unused;

  assign timeout_cyc_unused = ^TIMEOUT_CYC;
  assign timeout            = 1'b0;
`endif

  assign port_ok    = PORT_MASK[ptr[7:4]];
  assign port_hot   = 16'h0001 << ptr[7:4];
  assign OFFSET_SEL = 16'h0001 << ptr[3:0];
  assign RD_WR      = (state == READ) || (state == FETCH);

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_ADDR: if (ADDR_VLD) state_nxt = ADDR_RW ? READ : WAIT_PTR;
      WAIT_PTR:  if (RX_VLD)   state_nxt = WRITE;
      READ:      if (TX_REQ)   state_nxt = FETCH;
      FETCH:     if (fetch_late) state_nxt = READ;
      default:   ;
    endcase
    if (timeout)   state_nxt = IDLE;
    if (STOP_DET)  state_nxt = IDLE;
    if (START_DET) state_nxt = WAIT_ADDR;
  end

  // A read only proceeds while the FSM actually stays on the fetch path; any
  // START/STOP/timeout abandons it without a strobe or TX_VLD.
  assign rd_start   = (state == READ) && (state_nxt == FETCH);
  assign fetch_done = (state == FETCH) && fetch_late && (state_nxt == READ);

  always_ff @(posedge SYSCLK) begin
    if (!RESET_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge SYSCLK) begin
    if (!RESET_N) begin
      ptr         <= '0;
      PORT_CS_ALL <= '0;
      DIN         <= '0;
      TX_DATA     <= '0;
      TX_VLD      <= 1'b0;
      wr_pend     <= 1'b0;
      fetch_late  <= 1'b0;
    end else begin
      PORT_CS_ALL <= '0;
      TX_VLD      <= 1'b0;
      wr_pend     <= 1'b0;
      fetch_late  <= 1'b0;

      // Offset advances the cycle after the write strobe so OFFSET_SEL holds during it.
      if (wr_pend) ptr[3:0] <= ptr[3:0] + 4'd1;

      if (state == WAIT_PTR && RX_VLD) ptr <= RX_DATA;

      if (state == WRITE && RX_VLD) begin
        DIN     <= RX_DATA;
        wr_pend <= 1'b1;
        if (port_ok) PORT_CS_ALL <= port_hot;
      end

      if (rd_start && port_ok) PORT_CS_ALL <= port_hot;

      if (state == FETCH && !fetch_late && state_nxt == FETCH) fetch_late <= 1'b1;

      if (fetch_done) begin
        TX_DATA  <= port_ok ? RD_DATA : 8'hFF;
        TX_VLD   <= 1'b1;
        ptr[3:0] <= ptr[3:0] + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_decode.sv
// Self-checking bench for i2c_reg_decode: two instances (full and partial port mask)
// driven in lockstep and compared against a transaction-level pointer/port model.
module tb_i2c_reg_decode;

  localparam logic [15:0] MASK_A = 16'hFFFF;
  localparam logic [15:0] MASK_B = 16'h7FFF;

  logic        SYSCLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        START_DET = 1'b0, STOP_DET = 1'b0, ADDR_VLD = 1'b0, ADDR_RW = 1'b0;
  logic        RX_VLD = 1'b0, TX_REQ = 1'b0;
  logic [7:0]  RX_DATA = '0, RD_DATA = '0;

  logic [7:0]  a_txd, b_txd, a_din, b_din;
  logic        a_txv, b_txv, a_rdwr, b_rdwr;
  logic [15:0] a_cs, b_cs, a_off, b_off;

  int unsigned passed = 0;
  int unsigned total  = 0;
  logic [7:0]  mptr = '0;

  always #5 SYSCLK = ~SYSCLK;

  i2c_reg_decode #(.PORT_MASK(MASK_A), .TIMEOUT_CYC(16'd16)) u_dut (
    .SYSCLK(SYSCLK), .RESET_N(RESET_N), .START_DET(START_DET), .STOP_DET(STOP_DET),
    .ADDR_VLD(ADDR_VLD), .ADDR_RW(ADDR_RW), .RX_VLD(RX_VLD), .RX_DATA(RX_DATA),
    .TX_REQ(TX_REQ), .RD_DATA(RD_DATA), .TX_DATA(a_txd), .TX_VLD(a_txv),
    .PORT_CS_ALL(a_cs), .OFFSET_SEL(a_off), .RD_WR(a_rdwr), .DIN(a_din));

  i2c_reg_decode #(.PORT_MASK(MASK_B), .TIMEOUT_CYC(16'd16)) u_dut_m (
    .SYSCLK(SYSCLK), .RESET_N(RESET_N), .START_DET(START_DET), .STOP_DET(STOP_DET),
    .ADDR_VLD(ADDR_VLD), .ADDR_RW(ADDR_RW), .RX_VLD(RX_VLD), .RX_DATA(RX_DATA),
    .TX_REQ(TX_REQ), .RD_DATA(RD_DATA), .TX_DATA(b_txd), .TX_VLD(b_txv),
    .PORT_CS_ALL(b_cs), .OFFSET_SEL(b_off), .RD_WR(b_rdwr), .DIN(b_din));

  function automatic logic [15:0] exp_cs(input logic [15:0] mask, input logic [7:0] p);
    logic [15:0] oh;
    oh = '0;
    oh[p[7:4]] = mask[p[7:4]];
    return oh;
  endfunction

  function automatic logic [15:0] exp_off(input logic [7:0] p);
    logic [15:0] oh;
    oh = '0;
    oh[p[3:0]] = 1'b1;
    return oh;
  endfunction

  function automatic logic [7:0] bump(input logic [7:0] p);
    return {p[7:4], p[3:0] + 4'd1};
  endfunction

  task automatic tick();
    @(posedge SYSCLK);
    #1;
  endtask

  task automatic send(input logic st, input logic sp, input logic av, input logic rw,
                      input logic rv, input logic [7:0] d, input logic tr);
    START_DET = st; STOP_DET = sp; ADDR_VLD = av; ADDR_RW = rw;
    RX_VLD = rv; RX_DATA = d; TX_REQ = tr;
    tick();
    START_DET = 1'b0; STOP_DET = 1'b0; ADDR_VLD = 1'b0; RX_VLD = 1'b0; TX_REQ = 1'b0;
  endtask

  task automatic check_reset_outputs(input string nm);
    total++;
    if ({a_cs, b_cs, a_off, b_off, a_rdwr, b_rdwr, a_din, b_din, a_txd, b_txd, a_txv, b_txv} !==
        {16'h0, 16'h0, 16'h1, 16'h1, 1'b0, 1'b0, 8'h0, 8'h0, 8'h0, 8'h0, 1'b0, 1'b0})
      $display("FAIL %s: got cs=%h/%h off=%h/%h rdwr=%b/%b din=%h/%h tx=%h/%h vld=%b/%b want all reset values",
               nm, a_cs, b_cs, a_off, b_off, a_rdwr, b_rdwr, a_din, b_din, a_txd, b_txd, a_txv, b_txv);
    else passed++;
  endtask

  // START, write address, pointer byte; the pointer byte itself must not strobe.
  task automatic write_ptr(input logic [7:0] p);
    send(1, 0, 0, 0, 0, 8'h00, 0);
    send(0, 0, 1, 0, 0, 8'h00, 0);
    send(0, 0, 0, 0, 1, p, 0);
    mptr = p;
    tick();
    total++;
    if ({a_cs, b_cs, a_off, a_rdwr} !== {16'h0, 16'h0, exp_off(mptr), 1'b0})
      $display("FAIL ptr_load %h: got cs=%h/%h off=%h rdwr=%b want cs=0 off=%h rdwr=0",
               p, a_cs, b_cs, a_off, a_rdwr, exp_off(mptr));
    else passed++;
  endtask

  task automatic write_byte(input logic [7:0] d, input logic stop_with, input string nm);
    send(0, stop_with, 0, 0, 1, d, 0);
    total++;
    if ({a_cs, b_cs} !== {exp_cs(MASK_A, mptr), exp_cs(MASK_B, mptr)})
      $display("FAIL %s cs: got %h/%h want %h/%h", nm, a_cs, b_cs,
               exp_cs(MASK_A, mptr), exp_cs(MASK_B, mptr));
    else passed++;
    total++;
    if ({a_off, b_off, a_rdwr, b_rdwr, a_din} !== {exp_off(mptr), exp_off(mptr), 2'b00, d})
      $display("FAIL %s strobe_ctx: got off=%h/%h rdwr=%b/%b din=%h want off=%h rdwr=0 din=%h",
               nm, a_off, b_off, a_rdwr, b_rdwr, a_din, exp_off(mptr), d);
    else passed++;
    mptr = bump(mptr);
  endtask

  task automatic idle_check(input string nm);
    tick();
    total++;
    if ({a_cs, b_cs, a_off, b_off, a_txv, b_txv} !== {32'h0, exp_off(mptr), exp_off(mptr), 2'b00})
      $display("FAIL %s idle: got cs=%h/%h off=%h/%h vld=%b/%b want cs=0 off=%h vld=0",
               nm, a_cs, b_cs, a_off, b_off, a_txv, b_txv, exp_off(mptr));
    else passed++;
  endtask

  // Must be in READ. A second TX_REQ during the fetch must be ignored.
  task automatic read_byte(input logic [7:0] d, input string nm);
    send(0, 0, 0, 0, 0, 8'h00, 1);
    RD_DATA = ~d;
    total++;
    if ({a_cs, b_cs, a_rdwr, b_rdwr, a_txv, b_txv, a_off} !==
        {exp_cs(MASK_A, mptr), exp_cs(MASK_B, mptr), 4'b1100, exp_off(mptr)})
      $display("FAIL %s n1: got cs=%h/%h rdwr=%b/%b vld=%b/%b off=%h want cs=%h/%h rdwr=1 vld=0 off=%h",
               nm, a_cs, b_cs, a_rdwr, b_rdwr, a_txv, b_txv, a_off,
               exp_cs(MASK_A, mptr), exp_cs(MASK_B, mptr), exp_off(mptr));
    else passed++;
    send(0, 0, 0, 0, 0, 8'h00, 1);
    RD_DATA = d;
    total++;
    if ({a_cs, b_cs, a_rdwr, a_txv, b_txv} !== {32'h0, 1'b1, 2'b00})
      $display("FAIL %s n2: got cs=%h/%h rdwr=%b vld=%b/%b want cs=0 rdwr=1 vld=0",
               nm, a_cs, b_cs, a_rdwr, a_txv, b_txv);
    else passed++;
    tick();
    mptr = bump(mptr);
    total++;
    if ({a_txv, b_txv, a_txd, b_txd, a_off, a_rdwr} !==
        {2'b11, d, (MASK_B[mptr[7:4]] ? d : 8'hFF), exp_off(mptr), 1'b1})
      $display("FAIL %s n3: got vld=%b/%b tx=%h/%h off=%h rdwr=%b want vld=1 tx=%h/%h off=%h rdwr=1",
               nm, a_txv, b_txv, a_txd, b_txd, a_off, a_rdwr, d,
               (MASK_B[mptr[7:4]] ? d : 8'hFF), exp_off(mptr));
    else passed++;
    idle_check(nm);
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset_low");
    RESET_N = 1'b1;
    tick();
    check_reset_outputs("reset_release");
    mptr = '0;
  endtask

  task automatic test_write_basic();
    write_ptr(8'hF5);
    write_byte(8'h57, 1'b1, "w57_stop");
    idle_check("w57_after");
  endtask

  task automatic test_wrap();
    write_ptr(8'h3F);
    write_byte(8'hAA, 1'b0, "wrap_aa");
    write_byte(8'hBB, 1'b0, "wrap_bb");
    idle_check("wrap_after");
    send(0, 1, 0, 0, 0, 8'h00, 0);
  endtask

  task automatic test_read();
    write_ptr(8'h21);
    send(1, 0, 0, 0, 0, 8'h00, 0);
    send(0, 0, 1, 1, 0, 8'h00, 0);
    total++;
    if ({a_rdwr, b_rdwr} !== 2'b11)
      $display("FAIL read_state rdwr: got %b/%b want 1/1", a_rdwr, b_rdwr);
    else passed++;
    read_byte(8'h5C, "rd5c");
    send(0, 1, 0, 0, 0, 8'h00, 0);
  endtask

  task automatic test_mask();
    write_ptr(8'hF3);
    send(1, 0, 0, 0, 0, 8'h00, 0);
    send(0, 0, 1, 1, 0, 8'h00, 0);
    read_byte(8'($urandom), "mask_rd");
    send(0, 1, 0, 0, 0, 8'h00, 0);
  endtask

  task automatic test_reset_fetch();
    write_ptr(8'h47);
    send(1, 0, 0, 0, 0, 8'h00, 0);
    send(0, 0, 1, 1, 0, 8'h00, 0);
    RD_DATA = 8'h9E;
    send(0, 0, 0, 0, 0, 8'h00, 1);
    RESET_N = 1'b0;
    tick();
    check_reset_outputs("rst_fetch");
    RESET_N = 1'b1;
    mptr = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      tick();
      check_reset_outputs("rst_fetch_hold");
    end
  endtask

  task automatic test_timeout();
    logic [15:0] want;
    send(1, 0, 0, 0, 0, 8'h00, 0);
    repeat (40) tick();
    send(0, 0, 1, 0, 0, 8'h00, 0);
    send(0, 0, 0, 0, 1, 8'h4A, 0);
    send(0, 0, 0, 0, 1, 8'h99, 0);
`ifdef I2C_DEC_TIMEOUT_EN
    want = 16'h0000;
`else
    want = 16'h0010;
    mptr = 8'h4B;
`endif
    total++;
    if ({a_cs, b_cs} !== {want, want})
      $display("FAIL timeout cs: got %h/%h want %h/%h", a_cs, b_cs, want, want);
    else passed++;
    send(0, 1, 0, 0, 0, 8'h00, 0);
    total++;
    if (a_off !== exp_off(mptr))
      $display("FAIL timeout ptr: got off=%h want %h", a_off, exp_off(mptr));
    else passed++;
  endtask

  task automatic test_random();
    for (int unsigned it = 0; it < 40; it++) begin
      int unsigned n;
      logic        last_stop;
      n = $urandom_range(1, 4);
      write_ptr(8'($urandom));
      if ($urandom_range(0, 1) == 0) begin
        last_stop = 1'b0;
        for (int unsigned k = 0; k < n; k++) begin
          last_stop = (k == n - 1) && ($urandom_range(0, 1) == 1);
          write_byte(8'($urandom), last_stop, "rnd_wr");
          if ($urandom_range(0, 1) == 1) idle_check("rnd_wr_gap");
        end
        if (!last_stop) send(0, 1, 0, 0, 0, 8'h00, 0);
      end else begin
        send(1, 0, 0, 0, 0, 8'h00, 0);
        send(0, 0, 1, 1, 0, 8'h00, 0);
        for (int unsigned k = 0; k < n; k++) read_byte(8'($urandom), "rnd_rd");
        send(0, 1, 0, 0, 0, 8'h00, 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_wrap();
    test_read();
    test_mask();
    test_reset_fetch();
    test_timeout();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passed, total);
    $fatal(1);
  end

endmodule
